// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NREQ byte producers.
// Latches the winning byte, drives the start/data handshake and tracks busy/done.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 8,
    parameter int START_TMO = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [2:0]             cur_id,
    output logic                   arb_busy,
    output logic                   start_err
);

    localparam int CNT_W = $clog2(START_TMO + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state;
    logic [2:0]         last;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               grant_vld;
    logic [2:0]         grant_idx;
    logic [NREQ-1:0]    grant_oh;
    logic [DATA_W-1:0]  grant_byte;

    // Scan offsets from farthest to nearest so the nearest pending requester after 'last' wins.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_oh   = '0;
        grant_byte = '0;
        for (int s = NREQ; s >= 1; s--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && (((int'(last) + s) % NREQ) == j)) begin
                    grant_vld   = 1'b1;
                    grant_idx   = 3'(j);
                    grant_oh    = '0;
                    grant_oh[j] = 1'b1;
                    grant_byte  = req_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ack       <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            cur_id    <= '0;
            start_err <= 1'b0;
            last      <= 3'(NREQ - 1);
            tmo_cnt   <= '0;
        end else begin
            ack       <= '0;
            start_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld && !tx_busy) begin
                        tx_data <= grant_byte;
                        cur_id  <= grant_idx;
                        last    <= grant_idx;
                        ack     <= grant_oh;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_start <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A done arriving together with busy means the frame already finished.
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= tx_done ? IDLE : WAIT_DONE;
                    end else if (tmo_cnt == CNT_W'(START_TMO - 1)) begin
                        start_err <= 1'b1;
                        tx_start  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx stub
// (normal, mute and stuck-busy modes).
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int DATA_W    = 8;
    localparam int START_TMO = 16;
    localparam int FRAME     = 5;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_busy = 1'b0;
    logic                   tx_done = 1'b0;
    logic [2:0]             cur_id;
    logic                   arb_busy;
    logic                   start_err;

    logic [7:0] bytes [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    assign req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t q[$];

    int n_pass = 0;
    int n_chk  = 0;
    int mode   = 0;   // 0 normal uart, 1 never busy, 2 stuck busy
    int phase  = 0;
    int scnt   = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .START_TMO(START_TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .cur_id(cur_id), .arb_busy(arb_busy), .start_err(start_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic void push(input int id);
        exp_t e;
        e.id   = id;
        e.data = bytes[id];
        q.push_back(e);
    endfunction

    task automatic wait_ack(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (ack === '0 && n < 200);
        if (ack === '0) chk({"tmo_ack_", tag}, 0, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (tx_done !== 1'b1 && n < 200);
        if (tx_done !== 1'b1) chk({"tmo_done_", tag}, 0, 1);
    endtask

    // uart_tx stub: busy for FRAME+1 cycles after start, then a 1-cycle done.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (reset) begin
                phase   = 0;
                tx_busy = 1'b0;
            end else if (mode == 1) begin
                phase   = 0;
                tx_busy = 1'b0;
            end else if (mode == 2) begin
                phase   = 0;
                tx_busy = 1'b1;
            end else if (phase == 0) begin
                tx_busy = 1'b0;
                if (tx_start) begin
                    tx_busy = 1'b1;
                    scnt    = FRAME;
                    phase   = 1;
                end
            end else begin
                if (scnt == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                    phase   = 0;
                end else begin
                    scnt--;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic [7:0]      cur_byte = 8'h00;
        logic            prev_start = 1'b0;
        logic [NREQ-1:0] prev_ack = '0;
        exp_t            e;
        forever begin
            tick();
            if (!reset) begin
                if (ack !== '0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_ack", 32'(ack), 0);
                    end else begin
                        e = q.pop_front();
                        chk("ack", 32'(ack), 32'(1) << e.id);
                        chk("cur_id", 32'(cur_id), 32'(e.id));
                        chk("tx_data", 32'(tx_data), 32'(e.data));
                        cur_byte = e.data;
                    end
                end
                if (prev_ack !== '0) chk("start_latency", 32'(tx_start), 1);
                if (tx_start && !prev_start) chk("data_at_start", 32'(tx_data), 32'(cur_byte));
                if (!tx_start && prev_start) chk("data_at_end", 32'(tx_data), 32'(cur_byte));
            end
            prev_start = tx_start;
            prev_ack   = ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;

        // 1: reset state and a single 0xFF frame
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_cur_id", 32'(cur_id), 0);
        chk("rst_arb_busy", 32'(arb_busy), 0);
        chk("rst_start_err", 32'(start_err), 0);
        reset = 1'b0;
        tick();
        bytes[0] = 8'hFF;
        push(0);
        req = 4'b0001;
        wait_ack("t1");
        req = 4'b0000;
        wait_done("t1");
        tick();
        chk("t1_idle", 32'(arb_busy), 0);

        // 2: all four held after a fresh reset -> 0,1,2,3,0 with a 1-cycle IDLE gap
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        push(0); push(1); push(2); push(3); push(0);
        req = 4'b1111;
        wait_ack("t2");
        for (int k = 0; k < 4; k++) begin
            wait_done("t2");
            tick();
            chk("b2b_idle_gap", 32'(ack), 0);
            tick();
            chk("b2b_next_ack", 32'(ack != '0), 1);
        end
        req = 4'b0000;
        wait_done("t2_last");

        // 3: grant 2, then 1011 -> 3, 0, 1
        bytes = '{8'h30, 8'h31, 8'h32, 8'h33};
        push(2);
        req = 4'b0100;
        wait_ack("t3a");
        push(3); push(0); push(1);
        req = 4'b1011;
        wait_ack("t3b");
        wait_ack("t3c");
        wait_ack("t3d");
        req = 4'b0000;
        wait_done("t3");

        // 4: serializer never goes busy -> start_err after START_TMO cycles
        bytes[0] = 8'h40;
        bytes[1] = 8'h41;
        mode = 1;
        push(0);
        req = 4'b0011;
        wait_ack("t4");
        req = 4'b0010;
        push(1);
        tick();
        chk("t4_start", 32'(tx_start), 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (start_err !== 1'b1 && n < 40);
        chk("t4_err_latency", 32'(n), START_TMO);
        chk("t4_err_idle", 32'(arb_busy), 0);
        chk("t4_err_start_low", 32'(tx_start), 0);
        mode = 0;
        tick();
        chk("t4_err_pulse", 32'(start_err), 0);
        chk("t4_next_grant", 32'(ack), 32'b0010);
        req = 4'b0000;
        wait_done("t4");

        // 5: reset in WAIT_DONE, then pointer back at 3
        bytes[2] = 8'h77;
        push(2);
        req = 4'b0100;
        wait_ack("t5");
        req = 4'b0000;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(tx_busy && !tx_start) && n < 50);
        chk("t5_in_frame", 32'(arb_busy), 1);
        reset = 1'b1;
        tick();
        chk("t5_ack", 32'(ack), 0);
        chk("t5_tx_start", 32'(tx_start), 0);
        chk("t5_tx_data", 32'(tx_data), 0);
        chk("t5_cur_id", 32'(cur_id), 0);
        chk("t5_arb_busy", 32'(arb_busy), 0);
        chk("t5_start_err", 32'(start_err), 0);
        tick();
        reset = 1'b0;
        bytes[0] = 8'h10;
        bytes[3] = 8'h13;
        push(0);
        req = 4'b1001;
        wait_ack("t5a");
        req = 4'b1000;
        push(3);
        wait_ack("t5b");
        req = 4'b0000;
        wait_done("t5");

        // 6: withdrawn request and busy-in-IDLE block
        bytes[0] = 8'h60;
        push(0);
        req = 4'b0001;
        wait_ack("t6a");
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        wait_done("t6a");
        seen = 0;
        repeat (4) begin
            tick();
            if (ack !== '0) seen = 1;
        end
        chk("t6_withdrawn", 32'(seen), 0);
        mode = 2;
        tick();
        tick();
        bytes[2] = 8'h62;
        req = 4'b0100;
        seen = 0;
        repeat (8) begin
            tick();
            if (ack !== '0) seen = 1;
        end
        chk("t6_busy_block", 32'(seen), 0);
        push(2);
        mode = 0;
        wait_ack("t6b");
        chk("t6_grant", 32'(ack), 32'b0100);
        req = 4'b0000;
        wait_done("t6b");

        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
